seq_signed_div: RTL



---
 rtl/seq_div_pkg.sv | 17 +
 rtl/div_abs.sv | 18 +
 rtl/seq_signed_div.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared definitions for the sequential signed divider.
//   state_t : divider FSM states (IDLE, ITER, FIX, DONE)
//   N_DEF   : default divisor/remainder width
//   DIV_LAT : start-to-valid latency at N_DEF for a full (iterating) divide
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int N_DEF   = 4;
    localparam int DIV_LAT = 2 * N_DEF + 2;

endpackage

// File: rtl/div_abs.sv
// div_abs: combinational two's-complement magnitude.
//   a   : W-bit signed input
//   mag : W+1-bit unsigned magnitude (one extra bit so |most negative| fits)
module div_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W:0]   mag
);

    logic [W:0] ext;

    always_comb begin
        ext = {a[W-1], a};
        mag = a[W-1] ? ((W+1)'(0) - ext) : ext;
    end

endmodule

// File: rtl/seq_signed_div.sv
// seq_signed_div: multi-cycle signed divider, restoring division on
// magnitudes (one quotient bit per clock) followed by sign correction.
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-low
//   start : request, accepted only in IDLE or DONE
//   Z     : 2N-bit signed dividend
//   Y     : N-bit signed divisor
//   valid : result ready, held until the next accepted start
//   Q     : 2N-bit signed quotient, truncated toward zero
//   R     : N-bit signed remainder, sign follows Z
//   dz    : divide-by-zero flag (qualified by valid)
//   ovf   : quotient overflow flag, -2^(2N-1) / -1 (qualified by valid)
// Optional: define SEQ_DIV_EARLY_EXIT_EN to skip iteration when |Z| < |Y|.
module seq_signed_div
    import seq_div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] Z,
    input  logic [N-1:0]   Y,
    output logic           valid,
    output logic [2*N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           dz,
    output logic           ovf
);

    localparam int CW = $clog2(2 * N);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           zs, ys, dzr, ovfr;
    logic [2*N-1:0] zsh;      // dividend magnitude, consumed MSB first
    logic [2*N-1:0] quo;      // quotient magnitude
    logic [N:0]     ymag;
    logic [N-1:0]   rem;      // partial remainder, always < |Y|
    logic [N-1:0]   zlow;     // Z[N-1:0], the remainder for divide-by-zero

    logic [2*N:0]   zabs;
    logic [N:0]     yabs;
    logic [N:0]     shifted;
    logic           ge;
    logic           zmin_ym1;

    div_abs #(.W(2*N)) u_zabs (.a(Z), .mag(zabs));
    div_abs #(.W(N))   u_yabs (.a(Y), .mag(yabs));

    always_comb begin
        shifted  = {rem, zsh[2*N-1]};
        ge       = (shifted >= ymag);
        // Only -2^(2N-1) has that magnitude, and only -1 has magnitude 1 with sign set
        zmin_ym1 = Y[N-1] && (yabs == (N+1)'(1))
                   && (zabs == ((2*N+1)'(1) << (2*N-1)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            zs    <= 1'b0;
            ys    <= 1'b0;
            dzr   <= 1'b0;
            ovfr  <= 1'b0;
            zsh   <= '0;
            quo   <= '0;
            ymag  <= '0;
            rem   <= '0;
            zlow  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        valid <= 1'b0;
                        zs    <= Z[2*N-1];
                        ys    <= Y[N-1];
                        zsh   <= zabs[2*N-1:0];
                        ymag  <= yabs;
                        rem   <= '0;
                        quo   <= '0;
                        zlow  <= Z[N-1:0];
                        dzr   <= (Y == '0);
                        ovfr  <= zmin_ym1;
                        cnt   <= CW'(2*N-1);
                        if (Y == '0) begin
                            state <= FIX;
`ifdef SEQ_DIV_EARLY_EXIT_EN
                        end else if (zabs < {{N{1'b0}}, yabs}) begin
                            // Quotient is 0 and |Z| is the remainder; FIX restores the sign
                            rem   <= zabs[N-1:0];
                            state <= FIX;
`endif
                        end else begin
                            state <= ITER;
                        end
                    end else if (state == DONE) begin
                        valid <= 1'b1;
                    end
                end

                ITER: begin
                    zsh <= zsh << 1;
                    if (ge) begin
                        rem <= N'(shifted - ymag);
                        quo <= {quo[2*N-2:0], 1'b1};
                    end else begin
                        rem <= shifted[N-1:0];
                        quo <= {quo[2*N-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                FIX: begin
                    if (dzr) begin
                        Q   <= '1;
                        R   <= zlow;
                        dz  <= 1'b1;
                        ovf <= 1'b0;
                    end else begin
                        Q   <= (zs ^ ys) ? -quo : quo;
                        R   <= zs ? -rem : rem;
                        dz  <= 1'b0;
                        ovf <= ovfr;
                    end
                    state <= DONE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
